// File: rtl/mem_line_ctrl.sv
// rtl/mem_line_ctrl.sv - cache-line transfer controller: splits line refill/writeback into word accesses
module mem_line_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                               clk,
    input  logic                               arst,
    input  logic                               i_req_valid,
    output logic                               o_req_ready,
    input  logic [1:0]                         i_req_op,
    input  logic [ADDR_WIDTH-1:0]              i_req_addr,
    input  logic [ADDR_WIDTH-1:0]              i_req_wb_addr,
    input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] i_wline,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] o_rline,
    output logic                               o_done,
    output logic                               o_busy,
    output logic [ADDR_WIDTH-1:0]              o_mem_addr,
    output logic [DATA_WIDTH-1:0]              o_mem_wdata,
    output logic                               o_mem_we,
    output logic                               o_mem_re,
    input  logic [DATA_WIDTH-1:0]              i_mem_data,
    input  logic                               i_mem_access
);

    localparam int KW   = $clog2(WORDS_PER_LINE);
    localparam int OFFW = KW + 2;
    localparam int LW   = DATA_WIDTH * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [KW-1:0]           k_q;
    logic [KW-1:0]           k_inc;
    logic                    wb_then_rd_q;
    logic [ADDR_WIDTH-1:0]   rd_base_q;
    logic [ADDR_WIDTH-1:0]   wb_base_q;
    logic [LW-1:0]           wline_q;
    logic [LW-1:0]           rline_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic                    mem_we_q;
    logic                    mem_re_q;
    logic                    last_word;
    logic                    is_wb_op;
    logic [ADDR_WIDTH-1:0]   req_rd_base;
    logic [ADDR_WIDTH-1:0]   req_wb_base;

    // Byte address of word k within an aligned line base.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [KW-1:0] k);
        return base + {{(ADDR_WIDTH-OFFW){1'b0}}, k, 2'b00};
    endfunction

    // Clear the in-line offset bits to get the line base.
    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    endfunction

    assign k_inc       = k_q + 1'b1;
    assign last_word   = &k_q;
    assign is_wb_op    = (i_req_op == 2'b01) || (i_req_op == 2'b10);
    assign req_rd_base = line_base(i_req_addr);
    assign req_wb_base = line_base(i_req_wb_addr);

    // Transfer FSM; address, data and strobes for the next word are registered here
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            wb_then_rd_q <= 1'b0;
            rd_base_q    <= '0;
            wb_base_q    <= '0;
            wline_q      <= '0;
            rline_q      <= '0;
            done_q       <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_req_valid) begin
                        wb_then_rd_q <= (i_req_op == 2'b10);
                        rd_base_q    <= req_rd_base;
                        wb_base_q    <= req_wb_base;
                        wline_q      <= i_wline;
                        k_q          <= '0;
                        if (is_wb_op) begin
                            state_q     <= S_WRITE;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= req_wb_base;
                            mem_wdata_q <= i_wline[DATA_WIDTH-1:0];
                        end else begin
                            state_q    <= S_READ;
                            mem_re_q   <= 1'b1;
                            mem_addr_q <= req_rd_base;
                        end
                    end
                end
                S_WRITE: begin
                    if (i_mem_access) begin
                        if (last_word) begin
                            k_q      <= '0;
                            mem_we_q <= 1'b0;
                            if (wb_then_rd_q) begin
                                // Hand straight over to the read phase so the strobe has no gap.
                                state_q    <= S_READ;
                                mem_re_q   <= 1'b1;
                                mem_addr_q <= rd_base_q;
                            end else begin
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            k_q         <= k_inc;
                            mem_addr_q  <= word_addr(wb_base_q, k_inc);
                            mem_wdata_q <= wline_q[int'(k_inc)*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                end
                S_READ: begin
                    if (i_mem_access) begin
                        rline_q[int'(k_q)*DATA_WIDTH +: DATA_WIDTH] <= i_mem_data;
                        if (last_word) begin
                            k_q      <= '0;
                            mem_re_q <= 1'b0;
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                        end else begin
                            k_q        <= k_inc;
                            mem_addr_q <= word_addr(rd_base_q, k_inc);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready = (state_q == S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = done_q;
    assign o_rline     = rline_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_re    = mem_re_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// tb/tb_mem_line_ctrl.sv - self-checking bench for mem_line_ctrl
module tb_mem_line_ctrl;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          arst;
    logic          i_req_valid;
    logic          o_req_ready;
    logic [1:0]    i_req_op;
    logic [31:0]   i_req_addr;
    logic [31:0]   i_req_wb_addr;
    logic [127:0]  i_wline;
    logic [127:0]  o_rline;
    logic          o_done;
    logic          o_busy;
    logic [31:0]   o_mem_addr;
    logic [31:0]   o_mem_wdata;
    logic          o_mem_we;
    logic          o_mem_re;
    logic [31:0]   i_mem_data;
    logic          i_mem_access;

    mem_line_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .WORDS_PER_LINE(N)) dut (
        .clk(clk), .arst(arst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
        .i_req_addr(i_req_addr), .i_req_wb_addr(i_req_wb_addr), .i_wline(i_wline),
        .o_rline(o_rline), .o_done(o_done), .o_busy(o_busy),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we),
        .o_mem_re(o_mem_re), .i_mem_data(i_mem_data), .i_mem_access(i_mem_access)
    );

    always #5 clk = ~clk;

    // memory content is a fixed function of the byte address
    assign i_mem_data = o_mem_addr ^ 32'hA5A5_0000;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // memory responder: access strobe in the lat-th strobe cycle of every word
    int  lat_fixed = 1;   // 0 selects a fresh random latency 1..30 per word
    bit  spur_en   = 1'b0;
    initial begin
        int cnt = 0;
        int lat = 1;
        i_mem_access = 1'b0;
        forever begin
            @(negedge clk);
            if (!arst && (o_mem_we || o_mem_re)) begin
                if (cnt == 0) lat = (lat_fixed == 0) ? int'($urandom_range(1, 30)) : lat_fixed;
                cnt++;
                if (cnt >= lat) begin
                    i_mem_access = 1'b1;
                    cnt = 0;
                end else begin
                    i_mem_access = 1'b0;
                end
            end else begin
                cnt = 0;
                i_mem_access = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // monitor: log every completed word access and any strobe overlap
    logic [63:0] wr_log[$];
    logic [31:0] rd_log[$];
    int done_cnt = 0;
    int overlap  = 0;
    int re_cycles = 0;
    always @(posedge clk) begin
        if (!arst) begin
            if (i_mem_access && o_mem_we) wr_log.push_back({o_mem_addr, o_mem_wdata});
            if (i_mem_access && o_mem_re) rd_log.push_back(o_mem_addr);
            if (o_mem_we && o_mem_re) overlap++;
            if (o_mem_re) re_cycles++;
            if (o_done) done_cnt++;
        end
    end

    // reference model state
    logic [127:0] model_rline = '0;
    int done_base;

    // Compare logged traffic and the refill line against what the request should have produced.
    task automatic check_req(input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] wb, input logic [127:0] wline);
        logic [31:0] wbase, rbase, a;
        logic [127:0] line;
        bit do_wb, do_rd;
        do_wb = (op == 2'd1) || (op == 2'd2);
        do_rd = (op != 2'd1);
        wbase = wb & ~32'hF;
        rbase = addr & ~32'hF;
        check("wr_count", 128'(wr_log.size()), do_wb ? 128'(N) : 128'd0);
        if (do_wb && wr_log.size() == N)
            for (int k = 0; k < N; k++) begin
                a = wbase + 32'(4 * k);
                line = wline;
                check($sformatf("wr_word%0d", k), 128'(wr_log[k]), {64'd0, a, line[32*k +: 32]});
            end
        check("rd_count", 128'(rd_log.size()), do_rd ? 128'(N) : 128'd0);
        if (do_rd) begin
            for (int k = 0; k < N; k++) begin
                a = rbase + 32'(4 * k);
                model_rline[32*k +: 32] = a ^ 32'hA5A5_0000;
                if (rd_log.size() == N) check($sformatf("rd_addr%0d", k), 128'(rd_log[k]), 128'(a));
            end
        end
        check("rline", o_rline, model_rline);
        check("done_pulses", 128'(done_cnt - done_base), 128'd1);
        check("we_re_overlap", 128'(overlap), 128'd0);
    endtask

    // Issue one request and count cycles from the accept cycle to o_done.
    task automatic run_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wb,
                           input logic [127:0] wline, output int cyc);
        int w = 0;
        cyc = -1;
        while (!o_req_ready && w < 200) begin @(negedge clk); w++; end
        if (!o_req_ready) begin check("ready_timeout", 128'd0, 128'd1); return; end
        wr_log.delete(); rd_log.delete(); re_cycles = 0;
        done_base = done_cnt;
        i_req_op = op; i_req_addr = addr; i_req_wb_addr = wb; i_wline = wline;
        i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_req_addr = $urandom; i_req_wb_addr = $urandom; i_wline = ~wline; i_req_op = 2'($urandom);
        for (int c = 1; c <= 6000; c++) begin
            @(negedge clk);
            if (o_done) begin cyc = c; break; end
        end
        if (cyc < 0) check("done_timeout", 128'd0, 128'd1);
        else begin @(negedge clk); check("done_one_cycle", 128'(o_done), 128'd0); end
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [31:0]  addr;
        logic [31:0]  wb;
        logic [127:0] wline;
        int           lat;
        int           exp_cyc;
        logic [127:0] exp_rline;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        logic [1:0] rop;
        logic [31:0] raddr, rwb;
        logic [127:0] rwl;

        vecs[0] = '{2'd0, 32'h0000_0104, 32'h0, 128'h0, 1, 5,
                    {32'hA5A5_010C, 32'hA5A5_0108, 32'hA5A5_0104, 32'hA5A5_0100}};
        vecs[1] = '{2'd1, 32'h0, 32'h0000_0200, {32'h44, 32'h33, 32'h22, 32'h11}, 0, -1,
                    {32'hA5A5_010C, 32'hA5A5_0108, 32'hA5A5_0104, 32'hA5A5_0100}};
        vecs[2] = '{2'd2, 32'h0000_0400, 32'h0000_0300,
                    {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1234_5678, 32'h9ABC_DEF0}, 3, 25,
                    {32'hA5A5_040C, 32'hA5A5_0408, 32'hA5A5_0404, 32'hA5A5_0400}};
        vecs[3] = '{2'd3, 32'hFFFF_FFF4, 32'h0, 128'h0, 2, 9,
                    {32'h5A5A_FFFC, 32'h5A5A_FFF8, 32'h5A5A_FFF4, 32'h5A5A_FFF0}};
        vecs[4] = '{2'd1, 32'h0, 32'h0000_0FFC, {32'hA, 32'hB, 32'hC, 32'hD}, 1, 5,
                    {32'h5A5A_FFFC, 32'h5A5A_FFF8, 32'h5A5A_FFF4, 32'h5A5A_FFF0}};

        arst = 1'b1; i_req_valid = 1'b0; i_req_op = 2'd0;
        i_req_addr = '0; i_req_wb_addr = '0; i_wline = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 128'(o_req_ready), 128'd1);
        check("rst_busy_done_we_re", 128'({o_busy, o_done, o_mem_we, o_mem_re}), 128'd0);
        check("rst_addr_wdata", 128'({o_mem_addr, o_mem_wdata}), 128'd0);
        check("rst_rline", o_rline, 128'd0);
        arst = 1'b0;
        @(negedge clk);

        // table-driven directed cases
        for (int i = 0; i < 5; i++) begin
            lat_fixed = vecs[i].lat;
            run_req(vecs[i].op, vecs[i].addr, vecs[i].wb, vecs[i].wline, cyc);
            if (vecs[i].exp_cyc >= 0) check($sformatf("latency_v%0d", i), 128'(cyc), 128'(vecs[i].exp_cyc));
            check($sformatf("rline_v%0d", i), o_rline, vecs[i].exp_rline);
            if (vecs[i].op == 2'd1) check($sformatf("re_idle_v%0d", i), 128'(re_cycles), 128'd0);
            check_req(vecs[i].op, vecs[i].addr, vecs[i].wb, vecs[i].wline);
        end

        // back-to-back with valid held high and spurious access pulses outside transfers
        lat_fixed = 1; spur_en = 1'b1;
        wr_log.delete(); rd_log.delete();
        done_base = done_cnt;
        i_req_op = 2'd0; i_req_addr = 32'h0000_0500; i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_op = 2'd1; i_req_wb_addr = 32'h0000_0600; i_wline = {32'h4, 32'h3, 32'h2, 32'h1};
        begin
            int bad_ready = 0;
            int got = 0;
            for (int c = 0; c < 100 && got == 0; c++) begin
                @(negedge clk);
                if (o_done) got = 1;
                else if (o_req_ready) bad_ready++;
            end
            check("b2b_first_done", 128'(got), 128'd1);
            check("b2b_ready_low_busy", 128'(bad_ready), 128'd0);
            @(negedge clk);
            check("b2b_ready_after_done", 128'({o_req_ready, o_busy}), 128'b10);
            model_rline = {32'hA5A5_050C, 32'hA5A5_0508, 32'hA5A5_0504, 32'hA5A5_0500};
            check("b2b_rline1", o_rline, model_rline);
            check("b2b_reads1", 128'(rd_log.size()), 128'(N));
            @(posedge clk); #1;
            i_req_valid = 1'b0;
            check("b2b_second_accepted", 128'(o_busy), 128'd1);
            got = 0;
            for (int c = 0; c < 100 && got == 0; c++) begin
                @(negedge clk);
                if (o_done) got = 1;
            end
            check("b2b_second_done", 128'(got), 128'd1);
            check("b2b_wr_count", 128'(wr_log.size()), 128'(N));
            if (wr_log.size() == N)
                check("b2b_wr_last", 128'(wr_log[N-1]), {64'd0, 32'h0000_060C, 32'h4});
            check("b2b_rline_kept", o_rline, model_rline);
            repeat (4) @(negedge clk);
            check("spurious_idle", 128'({o_busy, o_mem_we, o_mem_re}), 128'd0);
            check("b2b_done_total", 128'(done_cnt - done_base), 128'd2);
        end
        spur_en = 1'b0;
        @(negedge clk);

        // asynchronous reset in the middle of the read phase
        lat_fixed = 2;
        done_base = done_cnt;
        rd_log.delete();
        i_req_op = 2'd0; i_req_addr = 32'h0000_0700; i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        for (int c = 0; c < 100 && rd_log.size() < 2; c++) @(negedge clk);
        check("mid_read_progress", 128'(rd_log.size()), 128'd2);
        #2 arst = 1'b1;
        #1;
        check("arst_strobes", 128'({o_mem_we, o_mem_re, o_busy, o_done}), 128'd0);
        check("arst_ready", 128'(o_req_ready), 128'd1);
        check("arst_addr", 128'({o_mem_addr, o_mem_wdata}), 128'd0);
        check("arst_rline", o_rline, 128'd0);
        model_rline = '0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        repeat (2) @(negedge clk);
        check("arst_no_done", 128'(done_cnt - done_base), 128'd0);
        lat_fixed = 1;
        run_req(2'd2, 32'h0000_0800, 32'h0000_0900, {32'h5, 32'h6, 32'h7, 32'h8}, cyc);
        check("post_reset_latency", 128'(cyc), 128'd9);
        check_req(2'd2, 32'h0000_0800, 32'h0000_0900, {32'h5, 32'h6, 32'h7, 32'h8});

        // randomized requests with random per-word latency against the model
        lat_fixed = 0;
        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom); raddr = $urandom; rwb = $urandom;
            rwl = {$urandom, $urandom, $urandom, $urandom};
            run_req(rop, raddr, rwb, rwl, cyc);
            check_req(rop, raddr, rwb, rwl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_line_ctrl.md
# mem_line_ctrl

Cache-line transfer controller that sits directly upstream of the external memory model / memory port. It accepts whole-line requests from the cache (refill, writeback, or writeback-then-refill), breaks each into word accesses, and holds each word's address, data and strobe until the memory reports a successful access. Memory latency is variable, so the block makes no fixed-latency assumption. A read line is assembled and delivered with a one-cycle done pulse.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width in bits
- ADDR_WIDTH, 32, byte address width
- WORDS_PER_LINE, 4, words per cache line; power of two, ≥ 2

Ports:
- clk  in  1  clock
- arst  in  1  reset, asynchronous, active-high
- i_req_valid  in  1  line request present
- o_req_ready  out  1  controller can accept a request (high only in IDLE)
- i_req_op  in  2  00 refill, 01 writeback, 10 writeback-then-refill, 11 reserved (treated as 00)
- i_req_addr  in  ADDR_WIDTH  refill line address (any byte address inside the line)
- i_req_wb_addr  in  ADDR_WIDTH  writeback line address
- i_wline  in  DATA_WIDTH*WORDS_PER_LINE  writeback line; word k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_rline  out  DATA_WIDTH*WORDS_PER_LINE  assembled refill line, same packing
- o_done  out  1  one-cycle pulse: request complete
- o_busy  out  1  request in progress (not IDLE)
- o_mem_addr  out  ADDR_WIDTH  word byte address to memory
- o_mem_wdata  out  DATA_WIDTH  write data to memory
- o_mem_we  out  1  write request/enable
- o_mem_re  out  1  read request
- i_mem_data  in  DATA_WIDTH  read data from memory (combinational from o_mem_addr)
- i_mem_access  in  1  successful-access strobe from memory

## Operation
- Handshake: the request is accepted when i_req_valid && o_req_ready at a rising edge. Accept latches op, both line bases and i_wline, and clears word index k to 0.
- Line base = address with low log2(WORDS_PER_LINE)+2 bits zeroed. Word k address = base + 4k. Words are transferred in ascending k.
- FSM states: IDLE, WRITE, READ, DONE.
  - IDLE: ready=1. On accept, go to WRITE for op 01/10, or READ for op 00/11.
  - WRITE: we=1, addr=wb_base+4k, wdata=latched word k. On i_mem_access: if k==WORDS_PER_LINE-1, clear k and go to READ (op 10) or DONE (op 01); otherwise k++.
  - READ: re=1, addr=rd_base+4k. On i_mem_access: store i_mem_data into o_rline word k; if last word go to DONE, otherwise k++.
  - DONE: o_done=1 for exactly one cycle, then IDLE.
- Strobes: we and re are never high together. Strobes stay asserted continuously across consecutive words of the same phase, with no idle gap.
- i_mem_access is ignored in IDLE and DONE.
- o_rline is written only in READ and holds its value until overwritten by the next refill. Writeback-only requests leave it unchanged.
- k is log2(WORDS_PER_LINE) bits wide. Address arithmetic is ADDR_WIDTH wide and wraps modulo 2^ADDR_WIDTH.
- i_wline, i_req_* changes after accept have no effect.

## Timing
- Reset values: state IDLE, k=0, o_rline=0, o_done=0, o_busy=0, o_mem_we=0, o_mem_re=0, o_mem_addr=0, o_mem_wdata=0, o_req_ready=1.
- Reset during a transfer returns to IDLE immediately. No partial done is issued, and strobes drop asynchronously.
- Strobes and address rise in the cycle after accept.
- A word completes in the cycle i_mem_access is high. The next word's address appears in the following cycle.
- An access strobe in the same cycle as the first strobe cycle counts (zero-wait memory).
- Latency: with per-word memory latency L cycles (access in the L-th strobe cycle), a single-phase request takes 1 + N·L cycles from accept to o_done, where N = WORDS_PER_LINE. Op 10 takes 1 + 2·N·L cycles.
- o_done is registered. A new request can be accepted the cycle after o_done, i.e. minimum 1 idle cycle between requests.
- o_mem_addr, o_mem_wdata and the strobes are registered or state-decoded outputs, free of combinational paths from i_mem_access.

## Test plan
- Refill, L=1: accept op 00 at addr 0x0000_0104, memory word at byte addr A = A ^ 0xA5A5_0000 → reads at 0x100, 0x104, 0x108, 0x10C; o_rline = {0xA5A5010C, 0xA5A50108, 0xA5A50104, 0xA5A50100}; o_done at accept+5.
- Writeback, random L in 1..30: op 01, wb_addr 0x200, i_wline words 0x11,0x22,0x33,0x44 → memory holds these at 0x200..0x20C; re never high; one o_done; o_rline unchanged.
- Op 10: wb 0x300 then refill 0x400, L=3 → 4 writes then 4 reads, no overlap of we/re, o_done at accept+25.
- Wrap and reserved op: op 11 at addr 0xFFFF_FFF4 → treated as refill; words read from 0xFFFF_FFF0..0xFFFF_FFFC.
- Back-to-back: i_req_valid held high → ready low while busy, second request accepted exactly one cycle after first o_done; spurious i_mem_access pulses in IDLE/DONE cause no state change.
- Reset mid-READ (after word 1) → outputs return to reset values asynchronously; no o_done; next request completes normally.
